// File: rtl/lu_pkg.sv
// ---------------------------------------------------------------------------
// lu_pkg
// Shared definitions for the bit-serial logic unit.
//   - lu_state_e : sequencer FSM state (IDLE -> SHIFT -> DONE -> IDLE)
//   - LU_*       : 4-bit truth-table function codes. Bit index = {a_bit,b_bit},
//                  so bit 3 is the a=1,b=1 minterm and bit 0 is a=0,b=0.
// ---------------------------------------------------------------------------
package lu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } lu_state_e;

  localparam logic [3:0] LU_AND   = 4'b1000;
  localparam logic [3:0] LU_OR    = 4'b1110;
  localparam logic [3:0] LU_XOR   = 4'b0110;
  localparam logic [3:0] LU_NAND  = 4'b0111;
  localparam logic [3:0] LU_NOR   = 4'b0001;
  localparam logic [3:0] LU_XNOR  = 4'b1001;
  localparam logic [3:0] LU_PASSA = 4'b1100;
  localparam logic [3:0] LU_NOTB  = 4'b0101;

endpackage

// File: rtl/lu_bit_slice.sv
// ---------------------------------------------------------------------------
// lu_bit_slice
// Combinational 1-bit logic unit: a 4:1 LUT mux.
// Ports:
//   a, b : operand bits
//   sel  : truth table, out = sel[{a,b}]
//   out  : result bit
// ---------------------------------------------------------------------------
module lu_bit_slice (
  input  logic       a,
  input  logic       b,
  input  logic [3:0] sel,
  output logic       out
);

  assign out = sel[{a, b}];

endmodule

// File: rtl/lu_serial_engine.sv
// ---------------------------------------------------------------------------
// lu_serial_engine
// Word-level sequencer that pushes two WIDTH-bit operands through a single
// lu_bit_slice one bit per clock, LSB first, and presents the assembled word.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operation request handshake (a, b, sel)
//   a, b                  : operands, sampled on acceptance only
//   sel                   : truth table, result bit = sel[{a_bit,b_bit}]
//   out_valid / out_ready : result handshake
//   result                : computed word (registered)
//   busy                  : high while in SHIFT
//   zero, parity          : result flags, only with LU_FLAGS_EN defined
//   dbg_state             : current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE and out_valid only in DONE, so
// the two handshakes can never complete in the same cycle; in_valid outside
// IDLE is simply ignored. Once raised, out_valid and result hold until
// out_ready is seen.
//
// Optional feature macro: LU_FLAGS_EN (adds zero/parity outputs).
// ---------------------------------------------------------------------------
module lu_serial_engine
  import lu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy,
`ifdef LU_FLAGS_EN
  output logic             zero,
  output logic             parity,
`endif
  output lu_state_e        dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  lu_state_e        state, next_state;
  logic [WIDTH-1:0] a_sr, b_sr, result_q;
  logic [3:0]       sel_q;
  logic [CW-1:0]    cnt;
  logic             accept, shift_en, bit_out;

  lu_bit_slice u_slice (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .sel (sel_q),
    .out (bit_out)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state and control decode
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    shift_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        // The last bit is written on this same edge.
        if (cnt == LAST_BIT) next_state = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath: operand shift registers, counter and result assembly.
  // Each new bit enters at the MSB, so after WIDTH shifts bit i of the
  // operands lands at result[i]. result is not cleared on acceptance; it is
  // fully overwritten by the WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      sel_q    <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      sel_q <= sel;
      cnt   <= '0;
    end else if (shift_en) begin
      a_sr     <= a_sr >> 1;
      b_sr     <= b_sr >> 1;
      cnt      <= cnt + CW'(1);
      result_q <= {bit_out, result_q[WIDTH-1:1]};
    end
  end

`ifdef LU_FLAGS_EN
  // Flags are accumulated bit by bit alongside the result, so they are final
  // on the same edge that enters DONE.
  logic zero_q, parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else if (accept) begin
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
    end else if (shift_en) begin
      zero_q   <= zero_q & ~bit_out;
      parity_q <= parity_q ^ bit_out;
    end
  end

  assign zero   = zero_q;
  assign parity = parity_q;
`endif

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_SHIFT);
  assign out_valid = (state == ST_DONE);
  assign result    = result_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_lu_serial_engine.sv
// ---------------------------------------------------------------------------
// tb_lu_serial_engine
// Self-checking bench for lu_serial_engine (WIDTH=16). Inputs are driven on
// the falling edge or #1 after the rising edge; outputs are sampled #1 after
// the rising edge. Expected words come from a word-level minterm model.
// ---------------------------------------------------------------------------
module tb_lu_serial_engine;
  import lu_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   sel = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] result;
  lu_state_e    dbg_state;
`ifdef LU_FLAGS_EN
  logic         zero, parity;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lu_serial_engine #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
`ifdef LU_FLAGS_EN
    .zero      (zero),
    .parity    (parity),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  // Each truth-table bit enables one minterm of the two operand words.
  function automatic logic [W-1:0] ref_lu(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [3:0] f);
    logic [W-1:0] r;
    r = '0;
    if (f[3]) r = r | ( x &  y);
    if (f[2]) r = r | ( x & ~y);
    if (f[1]) r = r | (~x &  y);
    if (f[0]) r = r | (~x & ~y);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Offers one operation, then waits (bounded) for out_valid. After the
  // acceptance edge the operand inputs are scrambled. With spam set, in_valid
  // is raised with junk operands from SHIFT cycle 6 until out_valid.
  // edges = rising edges after the acceptance edge until out_valid is seen.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic [3:0] ts, input bit spam,
                       output logic [W-1:0] res, output int edges,
                       output int busy_cnt, output bit ok);
    edges = 0; busy_cnt = 0; ok = 1'b0; res = '0;
    @(negedge clk);
    a = ta; b = tb_v; sel = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sel = 4'($urandom);
    for (int i = 1; i <= 4 * W; i++) begin
      if (busy) busy_cnt++;
      if (spam && i == 7) begin
        in_valid = 1'b1;
        a = W'($urandom); b = W'($urandom); sel = 4'($urandom);
      end
      @(posedge clk); #1;
      if (out_valid) begin
        edges = i; ok = 1'b1; res = result;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        result !== '0 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b busy=%b result=%h state=%0d, required 1 0 0 0000 0",
               in_ready, out_valid, busy, result, dbg_state);
    end
`ifdef LU_FLAGS_EN
    tests_run++;
    if (zero !== 1'b0 || parity !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: zero=%b parity=%b, required 0 0", zero, parity);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_and_latency();
    logic [W-1:0] res; int edges, bc; bit ok;
    out_ready = 1'b1;
    do_op(16'hF0F0, 16'hFF00, LU_AND, 1'b0, res, edges, bc, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL and_timeout: out_valid never rose");
    end
    // Acceptance edge plus WIDTH shift edges: WIDTH+1 edges in total.
    tests_run++;
    if (edges !== W) begin
      tests_failed++;
      $display("FAIL and_latency: edges after acceptance=%0d, required %0d", edges, W);
    end
    tests_run++;
    if (res !== 16'hF000) begin
      tests_failed++;
      $display("FAIL and_result: got %h, required f000", res);
    end
    tests_run++;
    if (bc !== W) begin
      tests_failed++;
      $display("FAIL and_busy: busy cycles=%0d, required %0d", bc, W);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL and_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_xor_nor();
    logic [W-1:0] res; int edges, bc; bit ok;
    do_op(16'hF0F0, 16'hFF00, LU_XOR, 1'b0, res, edges, bc, ok);
    tests_run++;
    if (!ok || res !== 16'h0FF0) begin
      tests_failed++;
      $display("FAIL xor_result: ok=%b got %h, required 0ff0", ok, res);
    end
    step();
    do_op(16'hF0F0, 16'hFF00, LU_NOR, 1'b0, res, edges, bc, ok);
    tests_run++;
    if (!ok || res !== 16'h000F) begin
      tests_failed++;
      $display("FAIL nor_result: ok=%b got %h, required 000f", ok, res);
    end
`ifdef LU_FLAGS_EN
    tests_run++;
    if (zero !== 1'b0 || parity !== 1'b0) begin
      tests_failed++;
      $display("FAIL nor_flags: zero=%b parity=%b, required 0 0", zero, parity);
    end
`endif
    step();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] res; int edges, bc; bit ok; bit stable;
    out_ready = 1'b0;
    do_op(16'h1234, 16'h1234, LU_XOR, 1'b0, res, edges, bc, ok);
    tests_run++;
    if (!ok || res !== 16'h0000) begin
      tests_failed++;
      $display("FAIL bp_result: ok=%b got %h, required 0000", ok, res);
    end
`ifdef LU_FLAGS_EN
    tests_run++;
    if (zero !== 1'b1 || parity !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_flags: zero=%b parity=%b, required 1 0", zero, parity);
    end
`endif
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = W'($urandom); b = W'($urandom); sel = 4'($urandom);
      step();
      if (out_valid !== 1'b1 || result !== 16'h0000 || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    tests_run++;
    if (!stable) begin
      tests_failed++;
      $display("FAIL bp_hold: out_valid=%b result=%h in_ready=%b, required 1 0000 0 throughout",
               out_valid, result, in_ready);
    end
    out_ready = 1'b1;
    step();
    step();
    step();
    // Nothing must have been queued by the ignored in_valid pulses.
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_no_queue: out_valid=%b busy=%b in_ready=%b, required 0 0 1",
               out_valid, busy, in_ready);
    end
  endtask

  task automatic test_input_stability();
    logic [W-1:0] res; int edges, bc; bit ok;
    do_op(16'hA5C3, 16'h0FF0, LU_XNOR, 1'b1, res, edges, bc, ok);
    tests_run++;
    if (!ok || res !== ref_lu(16'hA5C3, 16'h0FF0, LU_XNOR)) begin
      tests_failed++;
      $display("FAIL stability_result: ok=%b got %h, required %h", ok, res,
               ref_lu(16'hA5C3, 16'h0FF0, LU_XNOR));
    end
    step();
    step();
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stability_no_capture: busy=%b out_valid=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [W-1:0] res; int edges, bc; bit ok; bit spurious;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sel = LU_AND; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      tests_failed++;
      $display("FAIL midreset_values: in_ready=%b out_valid=%b busy=%b result=%h, required 1 0 0 0000",
               in_ready, out_valid, busy, result);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      step();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious = 1'b1;
    end
    tests_run++;
    if (spurious) begin
      tests_failed++;
      $display("FAIL midreset_idle: out_valid=%b in_ready=%b, required 0 1 after release",
               out_valid, in_ready);
    end
    do_op(16'h00FF, 16'h0F00, LU_OR, 1'b0, res, edges, bc, ok);
    tests_run++;
    if (!ok || res !== 16'h0FFF || edges !== W) begin
      tests_failed++;
      $display("FAIL midreset_newop: ok=%b got %h edges=%0d, required 0fff edges %0d", ok, res, edges, W);
    end
    step();
  endtask

  task automatic test_random_sweep();
    logic [W-1:0] res, ta, tb_v, exp; int edges, bc, hold; bit ok;
    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < 2; k++) begin
        ta = W'($urandom); tb_v = W'($urandom);
        exp = ref_lu(ta, tb_v, 4'(s));
        hold = $urandom_range(0, 2);
        out_ready = (hold == 0);
        do_op(ta, tb_v, 4'(s), 1'b0, res, edges, bc, ok);
        for (int h = 0; h < hold; h++) step();
        tests_run++;
        if (!ok || res !== exp || result !== exp || edges !== W) begin
          tests_failed++;
          $display("FAIL sweep sel=%h a=%h b=%h: ok=%b got %h held %h edges=%0d, required %h edges %0d",
                   4'(s), ta, tb_v, ok, res, result, edges, exp, W);
        end
`ifdef LU_FLAGS_EN
        tests_run++;
        if (zero !== (exp == '0) || parity !== ^exp) begin
          tests_failed++;
          $display("FAIL sweep_flags sel=%h: zero=%b parity=%b, required %b %b",
                   4'(s), zero, parity, (exp == '0), ^exp);
        end
`endif
        out_ready = 1'b1;
        step();
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_and_latency();
    test_xor_nor();
    test_backpressure();
    test_input_stability();
    test_reset_mid_shift();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
